// File: rtl/cordic_argred.sv
// Folds a full-range Q3.13 angle into [0, pi/2], drives one cordicdpath operation, and sign-corrects the cosine.
// Optional WAIT watchdog is compiled in with CORDIC_ARGRED_TIMEOUT_EN.
module cordic_argred #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] angle,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_cos,
   output logic        out_range,
   output logic        out_err,
   output logic [15:0] cd_theta,
   output logic        cd_bgn,
   input  logic        cd_fin,
   input  logic [15:0] cd_cos
);

   localparam logic signed [16:0] PI17   = 17'sh06488;
   localparam logic signed [16:0] HALF17 = 17'sh03244;

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;

   state_t      state;
   logic        neg_q;
   logic        range_q;

   logic signed [16:0] ang_ext, mag, clamp, red;
   logic               neg_n, range_n;
   logic [15:0]        theta_n, cos_fix;

   // 17-bit magnitude keeps |0x8000| = 0x8000 without wrapping.
   always_comb begin
      ang_ext = {angle[15], angle};
      mag     = ang_ext[16] ? -ang_ext : ang_ext;
      range_n = (mag > PI17);
      clamp   = range_n ? PI17 : mag;
      neg_n   = (clamp > HALF17);
      red     = neg_n ? (PI17 - clamp) : clamp;
      theta_n = 16'(red <<< 1);
      cos_fix = cd_cos;
      if (neg_q) begin
         cos_fix = (cd_cos == 16'h8000) ? 16'h7FFF : 16'(~cd_cos + 16'd1);
      end
   end

`ifdef CORDIC_ARGRED_TIMEOUT_EN
   localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
   logic [CW-1:0] cnt;
`else
   assign out_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state     <= S_IDLE;
         in_ready  <= 1'b1;
         cd_bgn    <= 1'b0;
         out_valid <= 1'b0;
         cd_theta  <= '0;
         neg_q     <= 1'b0;
         range_q   <= 1'b0;
         out_cos   <= '0;
         out_range <= 1'b0;
`ifdef CORDIC_ARGRED_TIMEOUT_EN
         out_err   <= 1'b0;
         cnt       <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  cd_theta <= theta_n;
                  neg_q    <= neg_n;
                  range_q  <= range_n;
                  in_ready <= 1'b0;
                  cd_bgn   <= 1'b1;
                  state    <= S_LAUNCH;
`ifdef CORDIC_ARGRED_TIMEOUT_EN
                  out_err  <= 1'b0;
`endif
               end
            end
            S_LAUNCH: begin
               cd_bgn <= 1'b0;
               state  <= S_WAIT;
`ifdef CORDIC_ARGRED_TIMEOUT_EN
               cnt    <= '0;
`endif
            end
            S_WAIT: begin
               // A result arriving on the expiry edge takes priority over the timeout.
               if (cd_fin) begin
                  out_cos   <= cos_fix;
                  out_range <= range_q;
                  out_valid <= 1'b1;
                  state     <= S_DONE;
`ifdef CORDIC_ARGRED_TIMEOUT_EN
                  out_err   <= 1'b0;
               end else if (cnt == LIMIT) begin
                  out_cos   <= '0;
                  out_range <= range_q;
                  out_err   <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
`endif
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
